stream_fifo_burst: RTL and testbench

//  Parametrised on-chip successor of the SRAM stream FIFO: buffers words from an upstream

---
 rtl/stream_fifo_pkg.sv | 32 +++
 rtl/stream_fifo_ram.sv | 29 ++
 rtl/stream_fifo_burst.sv | 245 ++++++++++++++++++++++++
 tb/tb_stream_fifo_burst.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared constants for the burst-streaming FIFO: register map, mode/status bit
// positions and the output FSM state type.
package stream_fifo_pkg;

   localparam logic [7:0] VERSION = 8'd2;

   localparam int unsigned AddrVersion = 0;
   localparam int unsigned AddrArm0    = 1;
   localparam int unsigned AddrArm1    = 2;
   localparam int unsigned AddrArm2    = 3;
   localparam int unsigned AddrSize0   = 4;
   localparam int unsigned AddrSize1   = 5;
   localparam int unsigned AddrSize2   = 6;
   localparam int unsigned AddrSize3   = 7;
   localparam int unsigned AddrMode    = 8;
   localparam int unsigned AddrStatus  = 9;

   localparam int unsigned ModeCont  = 0;
   localparam int unsigned ModeFlush = 1;

   localparam int unsigned StatBusy    = 0;
   localparam int unsigned StatFull    = 1;
   localparam int unsigned StatEmpty   = 2;
   localparam int unsigned StatOverrun = 3;

   typedef enum logic [1:0] {
      StIdle,
      StBurst,
      StGap
   } state_e;

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port buffer RAM with a registered read port, single clock.
module stream_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_fifo_burst.sv
// Burst-streaming FIFO: buffers upstream words in on-chip RAM and emits fixed-length
// bursts on a ready/write_n stream port, controlled through a byte-wide register file.
module stream_fifo_burst
   import stream_fifo_pkg::*;
#(
   parameter int unsigned ABUSWIDTH   = 16,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned BURST_LEN   = 8,
   parameter int unsigned COUNT_WIDTH = 24
) (
   input  logic                  BUS_CLK,
   input  logic                  RST,
   input  logic [ABUSWIDTH-1:0]  BUS_ADD,
   input  logic [7:0]            BUS_DATA_IN,
   output logic [7:0]            BUS_DATA_OUT,
   input  logic                  BUS_WR,
   input  logic                  BUS_RD,
   input  logic [DATA_WIDTH-1:0] FIFO_DATA,
   input  logic                  FIFO_EMPTY_IN,
   output logic                  FIFO_READ_NEXT_OUT,
   input  logic                  STREAM_READY,
   output logic                  STREAM_WRITE_N,
   output logic [DATA_WIDTH-1:0] STREAM_DATA
);

   localparam int unsigned PtrW = DEPTH_LOG2 + 1;

   logic [31:0]            addr;
   logic                   soft_rst, rst_all, arm_wr, rd_size, rd_status;
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q, occ;
   logic                   full, empty, push, pop, busy;
   logic [1:0]             mode_q;
   logic [23:0]            arm_q, arm_val;
   logic [COUNT_WIDTH-1:0] arm_cnt, rem_q, rem_d, pend_q, pend_d;
   logic [COUNT_WIDTH-1:0] occ_c, bl_c, rem_min, n_c, n_ext;
   logic                   pend_v_q, pend_v_d, overrun_q, overrun_d, cont_q, cont_d;
   logic                   start, gap_entry;
   state_e                 state_q, state_d;
   logic [PtrW-1:0]        left_q, left_d, n_q, n_d;
   logic [31:0]            size_now, size_q;
   logic [7:0]             rdata, data_out_q;
   logic                   pop_q1, stream_n_q;
   logic [DATA_WIDTH-1:0]  ram_rdata, stream_data_q;

   // A write to address 0 resets on the same edge that samples it.
   assign addr      = 32'(BUS_ADD);
   assign soft_rst  = BUS_WR && (addr == AddrVersion);
   assign rst_all   = RST || soft_rst;
   assign arm_wr    = BUS_WR && (addr == AddrArm2);
   assign rd_size   = BUS_RD && (addr == AddrSize0);
   assign rd_status = BUS_RD && (addr == AddrStatus);
   assign arm_val   = {BUS_DATA_IN, arm_q[15:0]};
   assign arm_cnt   = COUNT_WIDTH'(arm_val);

   assign occ   = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                  (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
   assign push  = !full && !FIFO_EMPTY_IN && !rst_all;
   assign busy  = (state_q != StIdle);
   assign size_now = 32'(occ) * (DATA_WIDTH / 8);

   assign FIFO_READ_NEXT_OUT = push;

   stream_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk_i   (BUS_CLK),
      .we_i    (push),
      .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
      .wdata_i (FIFO_DATA),
      .re_i    (pop),
      .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
      .rdata_o (ram_rdata)
   );

   // Burst start decision; continuous mode excludes the armed-count paths.
   always_comb begin
      occ_c   = COUNT_WIDTH'(occ);
      bl_c    = COUNT_WIDTH'(BURST_LEN);
      rem_min = (rem_q < bl_c) ? rem_q : bl_c;
      start   = 1'b0;
      n_c     = '0;
      if (STREAM_READY) begin
         if (mode_q[ModeCont]) begin
            if (occ_c >= bl_c) begin
               start = 1'b1;
               n_c   = bl_c;
            end
         end else if ((rem_q != '0) && (occ_c >= rem_min)) begin
            start = 1'b1;
            n_c   = rem_min;
         end else if (mode_q[ModeFlush] && (rem_q != '0) && (occ_c != '0)) begin
            start = 1'b1;
            n_c   = (occ_c < rem_min) ? occ_c : rem_min;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      left_d    = left_q;
      n_d       = n_q;
      cont_d    = cont_q;
      pop       = 1'b0;
      gap_entry = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StBurst;
               left_d  = PtrW'(n_c);
               n_d     = PtrW'(n_c);
               cont_d  = mode_q[ModeCont];
            end
         end
         StBurst: begin
            pop    = 1'b1;
            left_d = left_q - 1'b1;
            if (left_q == PtrW'(1)) begin
               state_d   = StGap;
               gap_entry = 1'b1;
            end
         end
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Arms landing mid-burst are parked and replace the count at gap entry.
   always_comb begin
      n_ext     = COUNT_WIDTH'(n_q);
      rem_d     = rem_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      overrun_d = overrun_q && !rd_status;
      if (gap_entry) begin
         pend_v_d = 1'b0;
         if (arm_wr) begin
            rem_d = arm_cnt;
         end else if (pend_v_q) begin
            rem_d = pend_q;
         end else if (!cont_q) begin
            rem_d = (rem_q >= n_ext) ? rem_q - n_ext : '0;
         end
      end else if (arm_wr && (state_q != StBurst)) begin
         rem_d = arm_cnt;
      end else if (arm_wr) begin
         pend_d   = arm_cnt;
         pend_v_d = 1'b1;
      end
      if (arm_wr && (state_q == StBurst)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         state_q   <= StIdle;
         left_q    <= '0;
         n_q       <= '0;
         cont_q    <= 1'b0;
         rem_q     <= '0;
         pend_q    <= '0;
         pend_v_q  <= 1'b0;
         overrun_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         left_q    <= left_d;
         n_q       <= n_d;
         cont_q    <= cont_d;
         rem_q     <= rem_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
         overrun_q <= overrun_d;
         wr_ptr_q  <= wr_ptr_q + PtrW'(push);
         rd_ptr_q  <= rd_ptr_q + PtrW'(pop);
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         AddrVersion: rdata = VERSION;
         AddrArm0:    rdata = arm_q[7:0];
         AddrArm1:    rdata = arm_q[15:8];
         AddrArm2:    rdata = arm_q[23:16];
         AddrSize0:   rdata = size_now[7:0];
         AddrSize1:   rdata = size_q[15:8];
         AddrSize2:   rdata = size_q[23:16];
         AddrSize3:   rdata = size_q[31:24];
         AddrMode:    rdata = {6'b0, mode_q};
         AddrStatus:  rdata = {4'b0, overrun_q, empty, full, busy};
         default:     rdata = '0;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         mode_q     <= '0;
         arm_q      <= '0;
         size_q     <= '0;
         data_out_q <= '0;
      end else begin
         if (BUS_WR) begin
            case (addr)
               AddrArm0: arm_q[7:0]   <= BUS_DATA_IN;
               AddrArm1: arm_q[15:8]  <= BUS_DATA_IN;
               AddrArm2: arm_q[23:16] <= BUS_DATA_IN;
               AddrMode: mode_q       <= BUS_DATA_IN[1:0];
               default:  ;
            endcase
         end
         if (rd_size) begin
            size_q <= size_now;
         end
         if (BUS_RD) begin
            data_out_q <= rdata;
         end
      end
   end

   // Two-stage output: RAM read register, then the stream output register.
   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         pop_q1        <= 1'b0;
         stream_n_q    <= 1'b1;
         stream_data_q <= '0;
      end else begin
         pop_q1     <= pop;
         stream_n_q <= !pop_q1;
         if (pop_q1) begin
            stream_data_q <= ram_rdata;
         end
      end
   end

   assign BUS_DATA_OUT   = data_out_q;
   assign STREAM_WRITE_N = stream_n_q;
   assign STREAM_DATA    = stream_data_q;

endmodule

// File: tb/tb_stream_fifo_burst.sv
// Directed bench for stream_fifo_burst: register vector table plus hand-written burst scenarios
// checked against an upstream word counter and a stream monitor.
module tb_stream_fifo_burst;

   logic        BUS_CLK = 1'b0;
   logic        RST;
   logic [15:0] BUS_ADD;
   logic [7:0]  BUS_DATA_IN;
   logic [7:0]  BUS_DATA_OUT;
   logic        BUS_WR;
   logic        BUS_RD;
   logic [15:0] FIFO_DATA;
   logic        FIFO_EMPTY_IN;
   logic        FIFO_READ_NEXT_OUT;
   logic        STREAM_READY;
   logic        STREAM_WRITE_N;
   logic [15:0] STREAM_DATA;

   int vec_cnt = 0;
   int miscmp  = 0;

   stream_fifo_burst #(
      .ABUSWIDTH   (16),
      .DATA_WIDTH  (16),
      .DEPTH_LOG2  (4),
      .BURST_LEN   (8),
      .COUNT_WIDTH (24)
   ) dut (
      .BUS_CLK            (BUS_CLK),
      .RST                (RST),
      .BUS_ADD            (BUS_ADD),
      .BUS_DATA_IN        (BUS_DATA_IN),
      .BUS_DATA_OUT       (BUS_DATA_OUT),
      .BUS_WR             (BUS_WR),
      .BUS_RD             (BUS_RD),
      .FIFO_DATA          (FIFO_DATA),
      .FIFO_EMPTY_IN      (FIFO_EMPTY_IN),
      .FIFO_READ_NEXT_OUT (FIFO_READ_NEXT_OUT),
      .STREAM_READY       (STREAM_READY),
      .STREAM_WRITE_N     (STREAM_WRITE_N),
      .STREAM_DATA        (STREAM_DATA)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   // Upstream source: word value equals its running index; up_lim bounds what is offered.
   int unsigned up_idx = 0;
   int unsigned up_lim = 0;
   always @(posedge BUS_CLK) if (FIFO_READ_NEXT_OUT) up_idx <= up_idx + 1;
   assign FIFO_DATA     = up_idx[15:0];
   assign FIFO_EMPTY_IN = (up_idx >= up_lim);

   // Stream monitor: records every strobed word and the length of each low run.
   logic [15:0] words[$];
   int          bursts[$];
   int          run = 0;
   always @(negedge BUS_CLK) begin
      if (STREAM_WRITE_N === 1'b0) begin
         words.push_back(STREAM_DATA);
         run = run + 1;
      end else if (run != 0) begin
         bursts.push_back(run);
         run = 0;
      end
   end

   typedef struct {
      bit          wr;
      int unsigned addr;
      logic [7:0]  data;
      logic [7:0]  exp;
   } reg_vec_t;

   reg_vec_t rv[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge BUS_CLK);
   endtask

   task automatic bus_wr(input int unsigned a, input logic [7:0] d);
      @(negedge BUS_CLK);
      BUS_ADD     = 16'(a);
      BUS_DATA_IN = d;
      BUS_WR      = 1'b1;
      @(negedge BUS_CLK);
      BUS_WR      = 1'b0;
   endtask

   task automatic bus_rd(input int unsigned a, output logic [7:0] d);
      @(negedge BUS_CLK);
      BUS_ADD = 16'(a);
      BUS_RD  = 1'b1;
      @(negedge BUS_CLK);
      BUS_RD  = 1'b0;
      d       = BUS_DATA_OUT;
   endtask

   task automatic arm(input int unsigned cnt);
      bus_wr(1, 8'(cnt));
      bus_wr(2, 8'(cnt >> 8));
      bus_wr(3, 8'(cnt >> 16));
   endtask

   task automatic do_reset();
      @(negedge BUS_CLK);
      RST          = 1'b1;
      STREAM_READY = 1'b0;
      up_lim       = up_idx;
      @(negedge BUS_CLK);
      RST = 1'b0;
   endtask

   task automatic push(input int n);
      up_lim = up_lim + n;
   endtask

   task automatic wait_bursts(input string name, input int target, input int budget);
      int cyc = 0;
      while (bursts.size() < target && cyc < budget) begin
         @(negedge BUS_CLK);
         cyc++;
      end
      check(name, 64'(bursts.size()), 64'(target));
   endtask

   task automatic wait_low(input string name, input int budget);
      int cyc = 0;
      while (STREAM_WRITE_N !== 1'b0 && cyc < budget) begin
         @(negedge BUS_CLK);
         cyc++;
      end
      check(name, 64'(STREAM_WRITE_N), 64'(0));
   endtask

   // Burst lengths beyond the third repeat the third expected length.
   task automatic check_stream(input string name, input int b0, input int w0, input int nb,
                               input int l0, input int l1, input int l2,
                               input int base, input int nw);
      int lens[3];
      lens = '{l0, l1, l2};
      check({name, "_nbursts"}, 64'(bursts.size() - b0), 64'(nb));
      for (int i = 0; i < nb; i++) begin
         if (b0 + i < bursts.size())
            check($sformatf("%s_len%0d", name, i), 64'(bursts[b0 + i]), 64'(lens[(i < 2) ? i : 2]));
      end
      check({name, "_nwords"}, 64'(words.size() - w0), 64'(nw));
      for (int i = 0; i < nw; i++) begin
         if (w0 + i < words.size())
            check($sformatf("%s_w%0d", name, i), 64'(words[w0 + i]), 64'((base + i) & 16'hffff));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int b0, w0, base;

      RST          = 1'b1;
      BUS_ADD      = '0;
      BUS_DATA_IN  = '0;
      BUS_WR       = 1'b0;
      BUS_RD       = 1'b0;
      STREAM_READY = 1'b0;
      up_lim       = 1;
      cycles(3);
      check("rst_pop_low", 64'(FIFO_READ_NEXT_OUT), 64'(0));
      check("rst_write_n", 64'(STREAM_WRITE_N), 64'(1));
      check("rst_sdata", 64'(STREAM_DATA), 64'(0));
      check("rst_busout", 64'(BUS_DATA_OUT), 64'(0));
      up_lim = up_idx;
      RST    = 1'b0;

      rv[0]  = '{1'b0, 0,     8'h00, 8'h02};
      rv[1]  = '{1'b0, 9,     8'h00, 8'h04};
      rv[2]  = '{1'b0, 8,     8'h00, 8'h00};
      rv[3]  = '{1'b1, 8,     8'h03, 8'h00};
      rv[4]  = '{1'b0, 8,     8'h00, 8'h03};
      rv[5]  = '{1'b1, 8,     8'h00, 8'h00};
      rv[6]  = '{1'b1, 1,     8'hA5, 8'h00};
      rv[7]  = '{1'b0, 1,     8'h00, 8'hA5};
      rv[8]  = '{1'b1, 2,     8'h5A, 8'h00};
      rv[9]  = '{1'b0, 2,     8'h00, 8'h5A};
      rv[10] = '{1'b0, 3,     8'h00, 8'h00};
      rv[11] = '{1'b0, 4,     8'h00, 8'h00};
      rv[12] = '{1'b0, 6,     8'h00, 8'h00};
      rv[13] = '{1'b0, 10,    8'h00, 8'h00};
      rv[14] = '{1'b0, 'h100, 8'h00, 8'h00};
      for (int i = 0; i < 15; i++) begin
         if (rv[i].wr) begin
            bus_wr(rv[i].addr, rv[i].data);
         end else begin
            bus_rd(rv[i].addr, d);
            check($sformatf("reg_vec%0d_addr%0d", i, rv[i].addr), 64'(d), 64'(rv[i].exp));
         end
      end

      // 1: 20 words, armed 20 -> bursts 8,8,4
      do_reset();
      b0 = bursts.size(); w0 = words.size(); base = int'(up_idx);
      arm(20);
      STREAM_READY = 1'b1;
      push(20);
      wait_bursts("t1_wait", b0 + 3, 300);
      cycles(20);
      check_stream("t1", b0, w0, 3, 8, 8, 4, base, 20);
      bus_rd(9, d);
      check("t1_status", 64'(d), 64'(4));

      // 2: armed count waits for enough words, then flush drains a partial burst
      do_reset();
      b0 = bursts.size(); w0 = words.size(); base = int'(up_idx);
      STREAM_READY = 1'b1;
      push(5);
      cycles(12);
      arm(12);
      cycles(20);
      check("t2_hold5", 64'(bursts.size() - b0), 64'(0));
      push(3);
      wait_bursts("t2_b8", b0 + 1, 100);
      push(2);
      cycles(20);
      check("t2_hold2", 64'(bursts.size() - b0), 64'(1));
      bus_wr(8, 8'h02);
      wait_bursts("t2_flush", b0 + 2, 100);
      bus_wr(8, 8'h00);
      push(2);
      wait_bursts("t2_rem2", b0 + 3, 100);
      push(2);
      cycles(30);
      check_stream("t2", b0, w0, 3, 8, 2, 2, base, 12);

      // 3: fill to full with the sink stalled, then continuous drains two bursts
      do_reset();
      b0 = bursts.size(); w0 = words.size(); base = int'(up_idx);
      push(17);
      cycles(30);
      bus_rd(9, d);
      check("t3_status_full", 64'(d), 64'(2));
      check("t3_pop_blocked", 64'(FIFO_READ_NEXT_OUT), 64'(0));
      check("t3_upstream_held", 64'(up_lim - up_idx), 64'(1));
      bus_wr(8, 8'h01);
      STREAM_READY = 1'b1;
      wait_bursts("t3_first", b0 + 1, 100);
      bus_rd(9, d);
      check("t3_full_clear", 64'(d[1]), 64'(0));
      wait_bursts("t3_second", b0 + 2, 100);
      cycles(20);
      check_stream("t3", b0, w0, 2, 8, 8, 8, base, 16);
      check("t3_upstream_drained", 64'(up_lim - up_idx), 64'(0));
      bus_wr(8, 8'h00);

      // 4: continuous streaming of 64 words across several pointer wraps
      do_reset();
      b0 = bursts.size(); w0 = words.size(); base = int'(up_idx);
      bus_wr(8, 8'h01);
      STREAM_READY = 1'b1;
      push(64);
      wait_bursts("t4_wait", b0 + 8, 500);
      cycles(20);
      check_stream("t4", b0, w0, 8, 8, 8, 8, base, 64);
      bus_rd(9, d);
      check("t4_status", 64'(d), 64'(4));
      bus_wr(8, 8'h00);

      // 5: re-arm during a burst, sticky overrun, coherent size snapshot
      do_reset();
      b0 = bursts.size(); w0 = words.size(); base = int'(up_idx);
      push(16);
      cycles(25);
      arm(8);
      bus_wr(1, 8'd4);
      STREAM_READY = 1'b1;
      wait_low("t5_first_low", 50);
      bus_wr(3, 8'h00);
      wait_bursts("t5_wait", b0 + 2, 100);
      cycles(20);
      check_stream("t5", b0, w0, 2, 8, 4, 4, base, 12);
      bus_rd(9, d);
      check("t5_overrun_set", 64'(d), 64'(8));
      bus_rd(9, d);
      check("t5_overrun_clr", 64'(d), 64'(0));
      push(2);
      cycles(10);
      bus_rd(4, d);
      check("t5_size0", 64'(d), 64'(12));
      push(3);
      cycles(10);
      bus_rd(5, d);
      check("t5_size1", 64'(d), 64'(0));
      bus_rd(6, d);
      check("t5_size2", 64'(d), 64'(0));
      bus_rd(7, d);
      check("t5_size3", 64'(d), 64'(0));
      bus_rd(4, d);
      check("t5_size_new", 64'(d), 64'(18));

      // 6: soft reset in the middle of a burst
      do_reset();
      push(16);
      cycles(25);
      bus_wr(8, 8'h01);
      STREAM_READY = 1'b1;
      wait_low("t6_first_low", 50);
      bus_wr(0, 8'h00);
      check("t6_write_n_high", 64'(STREAM_WRITE_N), 64'(1));
      cycles(5);
      check("t6_still_high", 64'(STREAM_WRITE_N), 64'(1));
      bus_rd(9, d);
      check("t6_status", 64'(d), 64'(4));
      bus_rd(0, d);
      check("t6_version", 64'(d), 64'(2));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule
